seq_alu: RTL

Parametrised multi-cycle ALU for the RISC-V datapath. It executes the base integer ops in one cycle and the RV32M multiply/divide/remainder ops iteratively, behind a valid/ready handshake. It sits between the register-read stage and writeback. The controller stalls the pipeline while `in_ready` is low or the result is not yet consumed.

---
 rtl/seq_alu.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle RISC-V ALU: single-cycle base ops, iterative RV32M multiply/divide behind valid/ready.
// Optional SEQ_ALU_FAST_MUL_EN selects a single-cycle combinational multiplier instead of shift-add.
module seq_alu #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     Zero,
   output logic                     busy
);
   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned W2 = 2 * DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam int unsigned OL = OPCODE_LENGTH;
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   localparam logic [OL-1:0] OP_AND  = OL'(5'b00000);
   localparam logic [OL-1:0] OP_OR   = OL'(5'b00001);
   localparam logic [OL-1:0] OP_ADD  = OL'(5'b00010);
   localparam logic [OL-1:0] OP_SLL  = OL'(5'b00011);
   localparam logic [OL-1:0] OP_SRL  = OL'(5'b00100);
   localparam logic [OL-1:0] OP_XOR  = OL'(5'b00101);
   localparam logic [OL-1:0] OP_SUB  = OL'(5'b00110);
   localparam logic [OL-1:0] OP_SRA  = OL'(5'b00111);
   localparam logic [OL-1:0] OP_EQ   = OL'(5'b01000);
   localparam logic [OL-1:0] OP_SLT  = OL'(5'b01100);
   localparam logic [OL-1:0] OP_SLTU = OL'(5'b01101);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [1:0]      op_q, op_d;
   logic            neg_q, neg_d, rneg_q, rneg_d;
   logic [W-1:0]    result_q, result_d;
   logic            zero_q, zero_d, out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d, busy_q, busy_d;

   logic            is_mul_c, is_div_c, sa_c, sb_c, a_neg_c, b_neg_c, div_ovf_c;
   logic [W-1:0]    a_mag_c, b_mag_c, alu_c;
   logic [CW-1:0]   shamt_c;
   logic [W:0]      mul_sum_c, div_sh_c, div_diff_c;
   logic [W2-1:0]   mul_acc_c, mul_fix_c, div_acc_c;
   logic [W-1:0]    mul_res_c, div_q_c, div_r_c, div_res_c;

   // Operand decode and magnitudes shared by multiply and divide
   always_comb begin
      is_mul_c  = (Operation[OL-1:2] == (OL-2)'(3'b100));
      is_div_c  = (Operation[OL-1:2] == (OL-2)'(3'b101));
      sa_c      = is_div_c ? ~Operation[0] : (Operation[1:0] == 2'b01 || Operation[1:0] == 2'b10);
      sb_c      = is_div_c ? ~Operation[0] : (Operation[1:0] == 2'b01);
      a_neg_c   = sa_c & SrcA[W-1];
      b_neg_c   = sb_c & SrcB[W-1];
      a_mag_c   = a_neg_c ? (~SrcA + W'(1)) : SrcA;
      b_mag_c   = b_neg_c ? (~SrcB + W'(1)) : SrcB;
      div_ovf_c = sa_c && (SrcA == MIN_VAL) && (SrcB == '1);
      shamt_c   = SrcB[CW-1:0];
   end

   // Single-cycle base ops
   always_comb begin
      alu_c = '0;
      case (Operation)
         OP_AND:  alu_c = SrcA & SrcB;
         OP_OR:   alu_c = SrcA | SrcB;
         OP_ADD:  alu_c = SrcA + SrcB;
         OP_SUB:  alu_c = SrcA - SrcB;
         OP_XOR:  alu_c = SrcA ^ SrcB;
         OP_SLT:  alu_c = W'($signed(SrcA) < $signed(SrcB));
         OP_SLTU: alu_c = W'(SrcA < SrcB);
         OP_EQ:   alu_c = W'(SrcA == SrcB);
         OP_SLL:  alu_c = SrcA << shamt_c;
         OP_SRL:  alu_c = SrcA >> shamt_c;
         OP_SRA:  alu_c = W'($signed(SrcA) >>> shamt_c);
         default: alu_c = '0;
      endcase
   end

   // One shift-add multiply step and one restoring divide step, with final sign fix-up
   always_comb begin
      mul_sum_c  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_acc_c  = {mul_sum_c, acc_q[W-1:1]};
      mul_fix_c  = neg_q ? (~mul_acc_c + W2'(1)) : mul_acc_c;
      mul_res_c  = (op_q == 2'b00) ? mul_fix_c[W-1:0] : mul_fix_c[W2-1:W];
      div_sh_c   = {acc_q[W2-1:W], acc_q[W-1]};
      div_diff_c = div_sh_c - {1'b0, opb_q};
      div_acc_c  = div_diff_c[W] ? {div_sh_c[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff_c[W-1:0], acc_q[W-2:0], 1'b1};
      div_q_c    = neg_q  ? (~div_acc_c[W-1:0] + W'(1))  : div_acc_c[W-1:0];
      div_r_c    = rneg_q ? (~div_acc_c[W2-1:W] + W'(1)) : div_acc_c[W2-1:W];
      div_res_c  = op_q[1] ? div_r_c : div_q_c;
   end

`ifdef SEQ_ALU_FAST_MUL_EN
   logic [W2-1:0] fast_prod_c, fast_fix_c;
   always_comb begin
      fast_prod_c = {{W{1'b0}}, a_mag_c} * {{W{1'b0}}, b_mag_c};
      fast_fix_c  = (a_neg_c ^ b_neg_c) ? (~fast_prod_c + W2'(1)) : fast_prod_c;
   end
`endif

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      op_d     = op_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               op_d    = Operation[1:0];
               state_d = DONE;
               if (is_mul_c) begin
`ifdef SEQ_ALU_FAST_MUL_EN
                  result_d = (Operation[1:0] == 2'b00) ? fast_fix_c[W-1:0] : fast_fix_c[W2-1:W];
`else
                  acc_d   = {{W{1'b0}}, b_mag_c};
                  opb_d   = a_mag_c;
                  neg_d   = a_neg_c ^ b_neg_c;
                  cnt_d   = '0;
                  state_d = MUL;
`endif
               end else if (is_div_c) begin
                  if (SrcB == '0) begin
                     result_d = Operation[1] ? SrcA : '1;
                  end else if (div_ovf_c) begin
                     result_d = Operation[1] ? '0 : MIN_VAL;
                  end else begin
                     acc_d   = {{W{1'b0}}, a_mag_c};
                     opb_d   = b_mag_c;
                     neg_d   = a_neg_c ^ b_neg_c;
                     rneg_d  = a_neg_c;
                     cnt_d   = '0;
                     state_d = DIV;
                  end
               end else begin
                  result_d = alu_c;
               end
            end
            MUL: begin
               acc_d = mul_acc_c;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(W-1)) begin
                  result_d = mul_res_c;
                  cnt_d    = '0;
                  state_d  = DONE;
               end
            end
            DIV: begin
               acc_d = div_acc_c;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(W-1)) begin
                  result_d = div_res_c;
                  cnt_d    = '0;
                  state_d  = DONE;
               end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d == MUL) || (state_d == DIV);
      zero_d      = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         rneg_q      <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         rneg_q      <= rneg_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign busy      = busy_q;

endmodule
